// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU op to the subunits, captures the result after RESULT_LATENCY cycles, and hands it to writeback
//   soc_clk, reset (sync, active-high), flush (sync abort)
//   dec_valid/dec_ready/dec_op/dec_rs1_val/dec_rs2_val/dec_rd : decode handshake
//   ALU_dat1/ALU_dat2/Instruction_to_ALU/dat_ready           : subunit drive
//   alu_result                                               : registered subunit result
//   wb_valid/wb_ready/wb_data/wb_rd                          : writeback handshake
//   busy                                                     : state is not IDLE
module alu_issue_ctrl #(
  parameter int RESULT_LATENCY = 1
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_op,
  input  logic [31:0] dec_rs1_val,
  input  logic [31:0] dec_rs2_val,
  input  logic [4:0]  dec_rd,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [4:0]  Instruction_to_ALU,
  output logic        dat_ready,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [4:0]  rd_q;
  logic        accept;
  // HOLD with wb_ready retires and accepts on the same edge
  assign dec_ready = ~reset & ~flush & ((state_q == IDLE) | ((state_q == HOLD) & wb_ready));
  assign accept    = dec_valid & dec_ready;
  assign busy      = state_q != IDLE;
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      rd_q               <= '0;
      ALU_dat1           <= '0;
      ALU_dat2           <= '0;
      Instruction_to_ALU <= '0;
      dat_ready          <= 1'b0;
      wb_valid           <= 1'b0;
      wb_data            <= '0;
      wb_rd              <= '0;
    end else if (flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dat_ready <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (accept) begin
      state_q            <= EXEC;
      cnt_q              <= '0;
      rd_q               <= dec_rd;
      ALU_dat1           <= dec_rs1_val;
      ALU_dat2           <= dec_rs2_val;
      Instruction_to_ALU <= dec_op;
      dat_ready          <= 1'b1;
      wb_valid           <= 1'b0;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q + 4'd1;
      // cnt counts cycles since the first dat_ready cycle; the subunit result is valid now
      if (cnt_q == 4'(RESULT_LATENCY)) begin
        state_q   <= HOLD;
        wb_data   <= alu_result;
        wb_rd     <= rd_q;
        wb_valid  <= 1'b1;
        dat_ready <= 1'b0;
      end
    end else if (state_q == HOLD && wb_ready) begin
      state_q  <= IDLE;
      wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a transaction-timing reference model
module tb_alu_issue_ctrl;
  logic        soc_clk = 1'b0;
  logic        reset, flush, dec_valid, wb_ready;
  logic [4:0]  dec_op, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val, alu_result;
  logic        dec_ready, dat_ready, wb_valid, busy;
  logic [31:0] ALU_dat1, ALU_dat2, wb_data;
  logic [4:0]  Instruction_to_ALU, wb_rd;
  logic        reset_3, flush_3, dec_valid_3, wb_ready_3;
  logic [4:0]  dec_op_3, dec_rd_3;
  logic [31:0] dec_rs1_val_3, dec_rs2_val_3, alu_result_3;
  logic        dec_ready_3, dat_ready_3, wb_valid_3, busy_3;
  logic [31:0] ALU_dat1_3, ALU_dat2_3, wb_data_3;
  logic [4:0]  Instruction_to_ALU_3, wb_rd_3;
  logic [3:0]  sub_cnt, sub_cnt_3;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  bit          m_ex, m_wb;
  int          m_acc;
  logic [31:0] m_a, m_b, m_wbd;
  logic [4:0]  m_op, m_rd, m_wbr;
  always #5 soc_clk = ~soc_clk;
  alu_issue_ctrl u_dut (
    .soc_clk(soc_clk), .reset(reset), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op(dec_op), .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_rd(dec_rd),
    .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .Instruction_to_ALU(Instruction_to_ALU),
    .dat_ready(dat_ready), .alu_result(alu_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .busy(busy)
  );
  alu_issue_ctrl #(.RESULT_LATENCY(3)) u_dut3 (
    .soc_clk(soc_clk), .reset(reset_3), .flush(flush_3), .dec_valid(dec_valid_3), .dec_ready(dec_ready_3),
    .dec_op(dec_op_3), .dec_rs1_val(dec_rs1_val_3), .dec_rs2_val(dec_rs2_val_3), .dec_rd(dec_rd_3),
    .ALU_dat1(ALU_dat1_3), .ALU_dat2(ALU_dat2_3), .Instruction_to_ALU(Instruction_to_ALU_3),
    .dat_ready(dat_ready_3), .alu_result(alu_result_3), .wb_valid(wb_valid_3), .wb_ready(wb_ready_3),
    .wb_data(wb_data_3), .wb_rd(wb_rd_3), .busy(busy_3)
  );
  function automatic logic [31:0] logop(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return op == 5'd15 ? (a & b) : op == 5'd16 ? (a | b) : op == 5'd17 ? (a ^ b) : 32'h0;
  endfunction
  // subunit models: the result is only valid in the cycle matching their latency, garbage otherwise
  always_ff @(posedge soc_clk) sub_cnt <= dat_ready ? sub_cnt + 4'd1 : 4'd0;
  always_ff @(posedge soc_clk) sub_cnt_3 <= dat_ready_3 ? sub_cnt_3 + 4'd1 : 4'd0;
  assign alu_result   = (dat_ready && sub_cnt == 4'd1) ? logop(Instruction_to_ALU, ALU_dat1, ALU_dat2) : 32'hDEADBEEF;
  assign alu_result_3 = (dat_ready_3 && sub_cnt_3 == 4'd3) ? 32'h12345678 : 32'hDEADBEEF;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // one cycle on the latency-1 instance; model tracks the op by its accept cycle number
  task automatic step(input bit r, input bit f, input bit dv, input bit wr, input logic [4:0] op,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    bit exp_rdy;
    reset = r; flush = f; dec_valid = dv; wb_ready = wr;
    dec_op = op; dec_rd = rd; dec_rs1_val = a; dec_rs2_val = b;
    #1;
    exp_rdy = !r && !f && ((!m_ex && !m_wb) || (m_wb && wr));
    check("dec_ready", dec_ready, exp_rdy);
    @(posedge soc_clk);
    if (r) begin
      m_ex = 0; m_wb = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_wbd = 0; m_wbr = 0;
    end else if (f) begin
      m_ex = 0; m_wb = 0;
    end else begin
      if (m_wb && wr) m_wb = 0;
      if (m_ex && cyc == m_acc + 1) begin
        m_ex = 0; m_wb = 1; m_wbd = logop(m_op, m_a, m_b); m_wbr = m_rd;
      end
      if (dv && exp_rdy) begin
        m_ex = 1; m_acc = cyc + 1; m_a = a; m_b = b; m_op = op; m_rd = rd;
      end
    end
    cyc++;
    @(negedge soc_clk);
    check("dat_ready", dat_ready, m_ex);
    check("wb_valid", wb_valid, m_wb);
    check("busy", busy, m_ex | m_wb);
    check("ALU_dat1", ALU_dat1, m_a);
    check("ALU_dat2", ALU_dat2, m_b);
    check("op_to_alu", Instruction_to_ALU, m_op);
    check("wb_data", wb_data, m_wbd);
    check("wb_rd", wb_rd, m_wbr);
  endtask
  task automatic idle(input bit wr, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, wr, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask
  initial begin
    reset_3 = 1; flush_3 = 0; dec_valid_3 = 0; wb_ready_3 = 0;
    dec_op_3 = 0; dec_rd_3 = 0; dec_rs1_val_3 = 0; dec_rs2_val_3 = 0;
    step(1, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 5'd15, 5'd5, 32'hF0F0F0F0, 32'hFF00FF00);
    idle(0, 1);
    check("and_not_yet", wb_valid, 1'b0);
    idle(0, 1);
    check("and_valid", wb_valid, 1'b1);
    check("and_data", wb_data, 32'hF000F000);
    check("and_rd", wb_rd, 5'd5);
    idle(1, 1);
    step(0, 0, 1, 1, 5'd16, 5'd1, 32'h0000FFFF, 32'h00FF0000);
    step(0, 0, 1, 1, 5'd17, 5'd2, 32'hAAAAAAAA, 32'hFFFFFFFF);
    step(0, 0, 1, 1, 5'd17, 5'd2, 32'hAAAAAAAA, 32'hFFFFFFFF);
    check("or_data", wb_data, 32'h00FFFFFF);
    check("gap", dat_ready, 1'b0);
    step(0, 0, 1, 1, 5'd17, 5'd2, 32'hAAAAAAAA, 32'hFFFFFFFF);
    check("xor_accepted", dat_ready, 1'b1);
    idle(0, 2);
    check("xor_data", wb_data, 32'h55555555);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 5'd15, 5'd3, 32'h12340000, 32'hFFFF0000);
    step(0, 0, 1, 1, 5'd15, 5'd3, 32'h12340000, 32'hFFFF0000);
    check("stall_accept", dat_ready, 1'b1);
    idle(1, 2);
    check("stall_data", wb_data, 32'h12340000);
    idle(1, 1);
    step(0, 0, 1, 1, 5'd16, 5'd4, 32'h1, 32'h2);
    idle(1, 1);
    step(0, 1, 0, 1, 5'd0, 5'd0, 32'h0, 32'h0);
    check("flush_busy", busy, 1'b0);
    step(0, 0, 1, 1, 5'd15, 5'd6, 32'hFFFFFFFF, 32'h0F0F0F0F);
    idle(0, 3);
    step(1, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    step(0, 1, 1, 1, 5'd15, 5'd9, 32'h5, 32'h5);
    step(0, 0, 1, 0, 5'd7, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(0, 2);
    check("inv_data", wb_data, 32'h0);
    check("inv_rd", wb_rd, 5'd11);
    idle(1, 1);
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] op;
      int k;
      k = int'($urandom_range(0, 4));
      op = k < 3 ? 5'(15 + k) : k == 3 ? 5'd7 : 5'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 6, op, 5'($urandom), $urandom, $urandom);
    end
    reset_3 = 0; dec_valid_3 = 1; dec_op_3 = 5'd15; dec_rd_3 = 5'd9;
    dec_rs1_val_3 = 32'hCAFEF00D; dec_rs2_val_3 = 32'h0;
    #1;
    check("l3_dec_ready", dec_ready_3, 1'b1);
    @(posedge soc_clk);
    @(negedge soc_clk);
    dec_valid_3 = 0;
    for (int i = 0; i < 8; i++) begin
      check("l3_dat_ready", dat_ready_3, i <= 3);
      check("l3_wb_valid", wb_valid_3, i >= 4);
      if (i == 4) begin
        check("l3_wb_data", wb_data_3, 32'h12345678);
        check("l3_wb_rd", wb_rd_3, 5'd9);
      end
      @(posedge soc_clk);
      @(negedge soc_clk);
    end
    wb_ready_3 = 1;
    @(posedge soc_clk);
    @(negedge soc_clk);
    check("l3_retire", wb_valid_3, 1'b0);
    check("l3_busy", busy_3, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
